sev_segment_reader: RTL and testbench
=====================================

// Module: sev_segment_reader
// PURPOSE
//  Receive-side counterpart of sevSegment_display: decodes a 7-segment drive pattern back to a BCD digit.
//  Registers the segment bus and requires the pattern to hold for STABLE_CYCLES consecutive clocks.
//  Then reports the digit with a one-cycle valid strobe, or flags blank/illegal patterns.
//  Sits on the display bus as a checker/loopback monitor for the display path.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical samples needed before acceptance (legal range 1..255)
//  SEG_ACTIVE_LOW 0  1: segments on when bit=0 (input inverted before decode); 0: on when bit=1
//  ERR_W          8  width of saturating illegal-pattern counter
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      synchronous reset, active low
//  seg          in   7      segment pattern, seg[0]=a .. seg[6]=g
//  bcd          out  4      last accepted digit 0..9
//  digit_valid  out  1      one-cycle strobe: bcd updated with newly accepted digit
//  blank        out  1      level: currently locked pattern is all-off
//  seg_err      out  1      one-cycle strobe: accepted pattern is not a legal digit or blank
//  err_count    out  ERR_W  number of seg_err strobes since reset, saturates at all-ones
//  locked       out  1      level: FSM in LOCKED
// BEHAVIOUR
//  Reset (rst_n=0 at a rising edge): all outputs 0, FSM=SETTLE, stable counter=0, sample regs=0.
//  Sampling: seg_q <= seg (normalised by SEG_ACTIVE_LOW) every edge; prev_q <= seg_q.
//  Stable counter cnt: prev_q!=seg_q -> 0; else saturating increment (stops at STABLE_CYCLES-1).
//  Decode table (active-high, hex {g..a}):
//   0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F blank=00; every other value is illegal.
//  FSM states:
//   SETTLE: wait for stability. At an edge where prev_q==seg_q and cnt==STABLE_CYCLES-1: accept seg_q, go LOCKED.
//    Legal digit: bcd<=digit, digit_valid=1 next cycle, blank<=0.
//    Blank: blank<=1, no strobe, bcd holds.
//    Illegal: seg_err=1 next cycle, err_count+1 (saturating), blank<=0, bcd holds.
//   LOCKED: outputs held, no further strobes while pattern unchanged. Any edge with prev_q!=seg_q -> SETTLE, locked<=0.
//  Latency: pattern applied before edge E0 and held -> strobe/locked high after edge E0+STABLE_CYCLES+1.
//  Glitches: a change shorter than STABLE_CYCLES samples is never accepted; counter restarts at 0 on each change.
//  Same pattern re-acquired after a glitch produces a new strobe (re-acceptance is deliberate).
//  STABLE_CYCLES=1: accept on first edge with prev_q==seg_q.
//  digit_valid and seg_err are never high together; each lasts exactly one cycle.
//  Reset mid-SETTLE or mid-strobe: strobe drops next edge, counter and err_count cleared, no stale acceptance.
//  Reset has priority over all other events on the same edge.
// TESTING (clk period 20, STABLE_CYCLES=4, SEG_ACTIVE_LOW=0)
//  rst_n=0 for 3 edges, seg=7F -> bcd=0, all flags 0, err_count=0, locked=0.
//  seg=6D held 100 time units -> digit_valid single pulse after 5th edge, bcd=5, locked=1, no second pulse.
//  seg: 06 for 2 edges, then 3F held -> no strobe for 06; one strobe with bcd=0 after 5 edges of 3F.
//  seg=49 (illegal) held -> seg_err one pulse, err_count=1, bcd keeps previous 0; ERR_W=2: 5 illegal acceptances -> err_count=3.
//  seg=00 held -> blank=1, locked=1, no digit_valid; then 6F -> blank=0, bcd=9 strobe.
//  rst_n=0 one edge during SETTLE of 4F -> no strobe, count restarts; 4F acceptance occurs 5 edges after reset release.

Source files
------------

// File: rtl/sev_segment_reader.sv
// Decodes a 7-segment drive pattern back to a BCD digit. A pattern is accepted only
// after it has held steady for STABLE_CYCLES consecutive samples.
module sev_segment_reader #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter int unsigned ERR_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       seg,
    output logic [3:0]       bcd,
    output logic             digit_valid,
    output logic             blank,
    output logic             seg_err,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    // state  | meaning
    // SETTLE | waiting for the sampled pattern to hold long enough
    // LOCKED | pattern accepted, outputs held until the pattern changes
    typedef enum logic {SETTLE, LOCKED} state_t;

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [6:0] seg_norm, seg_q, prev_q;
    logic [7:0] cnt;
    logic       accept, is_digit, is_blank, same;
    logic [3:0] dec_bcd;

    assign seg_norm = SEG_ACTIVE_LOW ? ~seg : seg;
    assign same     = (prev_q == seg_q);
    assign locked   = (state == LOCKED);

    always_comb begin
        is_digit = 1'b1;
        is_blank = 1'b0;
        dec_bcd  = 4'd0;
        case (seg_q)
            7'h3F: dec_bcd = 4'd0;
            7'h06: dec_bcd = 4'd1;
            7'h5B: dec_bcd = 4'd2;
            7'h4F: dec_bcd = 4'd3;
            7'h66: dec_bcd = 4'd4;
            7'h6D: dec_bcd = 4'd5;
            7'h7D: dec_bcd = 4'd6;
            7'h07: dec_bcd = 4'd7;
            7'h7F: dec_bcd = 4'd8;
            7'h6F: dec_bcd = 4'd9;
            7'h00: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default: is_digit = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            SETTLE: begin
                if (same && (cnt == CNT_MAX)) begin
                    accept    = 1'b1;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (!same) state_nxt = SETTLE;
            end
            default: state_nxt = SETTLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= SETTLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q       <= '0;
            prev_q      <= '0;
            cnt         <= '0;
            bcd         <= '0;
            blank       <= 1'b0;
            digit_valid <= 1'b0;
            seg_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            seg_q       <= seg_norm;
            prev_q      <= seg_q;
            digit_valid <= accept && is_digit;
            seg_err     <= accept && !is_digit && !is_blank;
            if (!same)                cnt <= '0;
            else if (cnt != CNT_MAX)  cnt <= cnt + 8'd1;
            if (accept) begin
                if (is_digit) begin
                    bcd   <= dec_bcd;
                    blank <= 1'b0;
                end else if (is_blank) begin
                    blank <= 1'b1;
                end else begin
                    blank <= 1'b0;
                    // counter saturates rather than wrapping
                    if (err_count != '1) err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sev_segment_reader.sv
// Randomized bench for sev_segment_reader: a run-length reference model predicts
// strobes into a scoreboard queue; a monitor checks strobes and levels on negedges.
module tb_sev_segment_reader;

    localparam int S = 4;

    logic       clk, rst_n;
    logic [6:0] seg;
    logic [3:0] bcd, bcd2;
    logic       digit_valid, blank, seg_err, locked;
    logic       digit_valid2, blank2, seg_err2, locked2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    sev_segment_reader #(.STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b0), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .bcd(bcd), .digit_valid(digit_valid),
        .blank(blank), .seg_err(seg_err), .err_count(err_count), .locked(locked));

    sev_segment_reader #(.STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b0), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .seg(seg), .bcd(bcd2), .digit_valid(digit_valid2),
        .blank(blank2), .seg_err(seg_err2), .err_count(err_count2), .locked(locked2));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {bit dv; int bcd; int err;} exp_t;
    exp_t q[$];

    int total = 0;
    int bad   = 0;
    bit started = 0;

    logic [6:0] dig_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    // Reference model: a pattern is accepted once the run of identical samples
    // seen before an edge reaches S+1 (one compare stage plus S stable counts).
    logic [6:0] last = '0;
    int  run = 2;
    bit  acc = 0;
    int  exp_bcd = 0, exp_err = 0, exp_err2 = 0;
    bit  exp_blank = 0, exp_locked = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            last = '0; run = 2; acc = 0;
            exp_bcd = 0; exp_err = 0; exp_err2 = 0; exp_blank = 0; exp_locked = 0;
        end else begin
            if (!acc && run >= S + 1) begin
                int d;
                exp_t e;
                d = -1;
                for (int i = 0; i < 10; i++) if (last == dig_tab[i]) d = i;
                acc = 1;
                exp_locked = 1;
                if (d >= 0) begin
                    exp_bcd = d;
                    exp_blank = 0;
                    e.dv = 1; e.bcd = d; e.err = exp_err;
                    q.push_back(e);
                end else if (last == 7'h00) begin
                    exp_blank = 1;
                end else begin
                    exp_blank = 0;
                    if (exp_err < 255) exp_err++;
                    if (exp_err2 < 3) exp_err2++;
                    e.dv = 0; e.bcd = exp_bcd; e.err = exp_err;
                    q.push_back(e);
                end
            end else if (run == 1) begin
                exp_locked = 0;
            end
            if (seg == last) run++;
            else begin
                run = 1;
                acc = 0;
            end
            last = seg;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("strobe_exclusive", int'(digit_valid & seg_err), 0);
            if (digit_valid || seg_err) begin
                if (q.size() == 0) chk("strobe_expected", q.size(), 1);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("strobe_kind", int'(digit_valid), int'(e.dv));
                    chk("strobe_bcd", int'(bcd), e.bcd);
                    chk("strobe_err_count", int'(err_count), e.err);
                end
            end else if (q.size() != 0) begin
                void'(q.pop_front());
                chk("strobe_seen", int'(digit_valid | seg_err), 1);
            end
            chk("bcd", int'(bcd), exp_bcd);
            chk("blank", int'(blank), int'(exp_blank));
            chk("locked", int'(locked), int'(exp_locked));
            chk("err_count", int'(err_count), exp_err);
            chk("err_count_w2", int'(err_count2), exp_err2);
        end
    end

    task automatic hold(input logic [6:0] p, input int n);
        seg = p;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [6:0] p;
        rst_n = 1'b0;
        seg   = 7'h7F;
        @(negedge clk);
        started = 1;
        repeat (2) @(negedge clk);
        chk("reset_bcd", int'(bcd), 0);
        chk("reset_flags", int'({digit_valid, blank, seg_err, locked}), 0);
        chk("reset_err_count", int'(err_count), 0);

        rst_n = 1'b1;
        hold(7'h7F, 10);

        seg = 7'h6D;
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (digit_valid) lat = i;
        end
        chk("latency_6d", lat, S + 1);
        hold(7'h6D, 8);

        hold(7'h06, 2);
        hold(7'h3F, 10);
        hold(7'h49, 10);
        for (int i = 0; i < 5; i++) begin
            hold(7'h49, 8);
            hold(7'h12, 8);
        end
        hold(7'h00, 10);
        hold(7'h6F, 10);

        hold(7'h4F, 2);
        rst_n = 1'b0;
        hold(7'h4F, 1);
        rst_n = 1'b1;
        hold(7'h4F, 10);

        hold(7'h3F, 10);
        hold(7'h06, 1);
        hold(7'h3F, 10);
        hold(7'h3F, 1);
        hold(7'h3F, 3);
        hold(7'h06, 3);
        hold(7'h3F, 10);

        repeat (300) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 5)      p = dig_tab[$urandom_range(0, 9)];
            else if (r == 6) p = 7'h00;
            else             p = 7'($urandom);
            if (r == 9) begin
                rst_n = 1'b0;
                hold(p, 1);
                rst_n = 1'b1;
            end
            hold(p, int'($urandom_range(1, 8)));
        end
        hold(7'h5B, 12);

        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
